// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file board.
// Index type is sized for the default 8-register configuration.
package regfile_pkg;

   localparam int unsigned DEF_NUM_REGS = 8;
   localparam int unsigned ZERO_IDX     = 0;

   typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_index_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } regfile_state_t;

endpackage

// File: rtl/regfile_bank.sv
// One bank of general registers: a single write port, two combinational
// read ports, and register 0 forced to read zero.
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned WIDTH    = 16,
   localparam int unsigned IW      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we_i,
   input  logic [IW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [IW-1:0]    ra_addr_i,
   input  logic [IW-1:0]    rb_addr_i,
   output logic [WIDTH-1:0] ra_data_o,
   output logic [WIDTH-1:0] rb_data_o
);

   logic [WIDTH-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      end else if (we_i && (waddr_i != IW'(ZERO_IDX))) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o = (ra_addr_i == IW'(ZERO_IDX)) ? '0 : mem_q[ra_addr_i];
   assign rb_data_o = (rb_addr_i == IW'(ZERO_IDX)) ? '0 : mem_q[rb_addr_i];

endmodule

// File: rtl/register_file_board.sv
// Register file feeding the ALU board: registered A/B operands, write-through
// forwarding and a sequenced bulk clear. REGFILE_BANKS_EN adds a second bank.
module register_file_board
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned WIDTH    = 16,
   localparam int unsigned IW      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    a_sel,
   input  logic [IW-1:0]    b_sel,
   input  logic             read_en,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [IW-1:0]    write_sel,
   input  logic             write_en,
   input  logic [WIDTH-1:0] d_in,
   input  logic             clear_req,
   output logic             busy,
   input  logic             bank_sel
);

   regfile_state_t   state_q, state_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] rd_a, rd_b;
   logic             wr_en;
   logic [IW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   assign busy = (state_q == CLEAR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d = CLEAR;
               cnt_d   = IW'(1);
            end
         end
         CLEAR: begin
            if (cnt_q == IW'(NUM_REGS - 1)) state_d = IDLE;
            else                            cnt_d   = cnt_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // While clearing, the single write port is stolen by the clear sequencer.
   always_comb begin
      wr_en   = busy ? 1'b1  : write_en;
      wr_addr = busy ? cnt_q : write_sel;
      wr_data = busy ? '0    : d_in;
   end

`ifdef REGFILE_BANKS_EN
   logic             clr_bank_q, clr_bank_d;
   logic             wr_bank;
   logic [WIDTH-1:0] rd_a0, rd_b0, rd_a1, rd_b1;

   assign clr_bank_d = (state_q == IDLE && clear_req) ? bank_sel : clr_bank_q;
   assign wr_bank    = busy ? clr_bank_q : bank_sel;

   always_ff @(posedge clk) begin
      if (reset) clr_bank_q <= 1'b0;
      else       clr_bank_q <= clr_bank_d;
   end

   regfile_bank #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_bank0 (
      .clk(clk), .reset(reset),
      .we_i(wr_en && !wr_bank), .waddr_i(wr_addr), .wdata_i(wr_data),
      .ra_addr_i(a_sel), .rb_addr_i(b_sel),
      .ra_data_o(rd_a0), .rb_data_o(rd_b0)
   );

   regfile_bank #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_bank1 (
      .clk(clk), .reset(reset),
      .we_i(wr_en && wr_bank), .waddr_i(wr_addr), .wdata_i(wr_data),
      .ra_addr_i(a_sel), .rb_addr_i(b_sel),
      .ra_data_o(rd_a1), .rb_data_o(rd_b1)
   );

   assign rd_a = bank_sel ? rd_a1 : rd_a0;
   assign rd_b = bank_sel ? rd_b1 : rd_b0;
`else
   logic unused_bank_sel;
   assign unused_bank_sel = bank_sel;

   regfile_bank #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) u_bank0 (
      .clk(clk), .reset(reset),
      .we_i(wr_en), .waddr_i(wr_addr), .wdata_i(wr_data),
      .ra_addr_i(a_sel), .rb_addr_i(b_sel),
      .ra_data_o(rd_a), .rb_data_o(rd_b)
   );
`endif

   // A same-cycle write to the selected register bypasses the array.
   always_comb begin
      a_d = rd_a;
      b_d = rd_b;
      if (write_en && (a_sel == write_sel) && (a_sel != IW'(ZERO_IDX))) a_d = d_in;
      if (write_en && (b_sel == write_sel) && (b_sel != IW'(ZERO_IDX))) b_d = d_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
      end else if (read_en && !busy) begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign a = a_q;
   assign b = b_q;

endmodule

// File: tb/tb_register_file_board.sv
// Self-checking bench for register_file_board against a behavioural model.
// Define REGFILE_BANKS_EN to also exercise the two-bank build.
module tb_register_file_board;

   localparam int NR = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  a_sel = '0, b_sel = '0, write_sel = '0;
   logic        read_en = 1'b0, write_en = 1'b0, clear_req = 1'b0, bank_sel = 1'b0;
   logic [15:0] d_in = '0;
   logic [15:0] a, b;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_regs [2][NR];
   logic [15:0] m_a, m_b;
   int          m_busy_left;
   int          m_clr_bank;

   register_file_board #(.NUM_REGS(NR), .WIDTH(16)) dut (
      .clk(clk), .reset(reset), .a_sel(a_sel), .b_sel(b_sel), .read_en(read_en),
      .a(a), .b(b), .write_sel(write_sel), .write_en(write_en), .d_in(d_in),
      .clear_req(clear_req), .busy(busy), .bank_sel(bank_sel)
   );

   always #5 clk = ~clk;

   function automatic int cur_bank();
`ifdef REGFILE_BANKS_EN
      return int'(bank_sel);
`else
      return 0;
`endif
   endfunction

   // Effect of one rising edge given the inputs currently driven.
   task automatic model_edge();
      int bk;
      bk = cur_bank();
      if (reset) begin
         for (int k = 0; k < 2; k++)
            for (int r = 0; r < NR; r++) m_regs[k][r] = 16'h0;
         m_a = 16'h0;
         m_b = 16'h0;
         m_busy_left = 0;
      end else if (m_busy_left > 0) begin
         m_regs[m_clr_bank][NR - m_busy_left] = 16'h0;
         m_busy_left--;
      end else begin
         if (read_en) begin
            m_a = (write_en && write_sel == a_sel && a_sel != 0) ? d_in : m_regs[bk][a_sel];
            m_b = (write_en && write_sel == b_sel && b_sel != 0) ? d_in : m_regs[bk][b_sel];
         end
         if (write_en && write_sel != 0) m_regs[bk][write_sel] = d_in;
         if (clear_req) begin
            m_busy_left = NR - 1;
            m_clr_bank  = bk;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      reset = 0; read_en = 0; write_en = 0; clear_req = 0;
   endtask

   task automatic test_reset();
      reset = 1; tick(); quiet();
      read_en = 1; a_sel = 3; b_sel = 5; tick(); quiet();
      n_vec++; if (a !== 16'h0) begin n_err++; $display("FAIL reset_a: got %h want %h", a, 16'h0); end
      n_vec++; if (b !== 16'h0) begin n_err++; $display("FAIL reset_b: got %h want %h", b, 16'h0); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_write_read();
      write_en = 1; write_sel = 2; d_in = 16'hBEEF; tick(); quiet();
      read_en = 1; a_sel = 2; b_sel = 0; tick(); quiet();
      n_vec++; if (a !== 16'hBEEF) begin n_err++; $display("FAIL wr_rd_a: got %h want %h", a, 16'hBEEF); end
      n_vec++; if (b !== 16'h0) begin n_err++; $display("FAIL wr_rd_b: got %h want %h", b, 16'h0); end
      write_en = 1; write_sel = 0; d_in = 16'h1234; tick(); quiet();
      read_en = 1; a_sel = 0; b_sel = 2; tick(); quiet();
      n_vec++; if (a !== 16'h0) begin n_err++; $display("FAIL r0_drop: got %h want %h", a, 16'h0); end
      n_vec++; if (b !== 16'hBEEF) begin n_err++; $display("FAIL r2_keep: got %h want %h", b, 16'hBEEF); end
   endtask

   task automatic test_forward();
      write_en = 1; write_sel = 4; d_in = 16'hA5A5; read_en = 1; a_sel = 4; b_sel = 4; tick(); quiet();
      n_vec++; if (a !== 16'hA5A5) begin n_err++; $display("FAIL fwd_a: got %h want %h", a, 16'hA5A5); end
      n_vec++; if (b !== 16'hA5A5) begin n_err++; $display("FAIL fwd_b: got %h want %h", b, 16'hA5A5); end
      write_en = 1; write_sel = 0; d_in = 16'h7777; read_en = 1; a_sel = 0; b_sel = 2; tick(); quiet();
      n_vec++; if (a !== 16'h0) begin n_err++; $display("FAIL fwd_r0: got %h want %h", a, 16'h0); end
      n_vec++; if (b !== 16'hBEEF) begin n_err++; $display("FAIL fwd_other: got %h want %h", b, 16'hBEEF); end
   endtask

   task automatic test_clear();
      int cnt;
      for (int r = 1; r < NR; r++) begin
         write_en = 1; write_sel = 3'(r); d_in = 16'(r * 16'h0011); tick();
      end
      quiet();
      read_en = 1; a_sel = 1; b_sel = 7; tick(); quiet();
      n_vec++; if (a !== 16'h0011 || b !== 16'h0077) begin
         n_err++; $display("FAIL clr_preload: got %h/%h want 0011/0077", a, b); end
      clear_req = 1; tick(); quiet();
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         n_vec++; if (busy !== (i < NR - 1)) begin
            n_err++; $display("FAIL clr_busy_seq[%0d]: got %b want %b", i, busy, (i < NR - 1)); end
         if (busy === 1'b1) begin
            cnt++;
            n_vec++; if (a !== 16'h0011 || b !== 16'h0077) begin
               n_err++; $display("FAIL clr_hold[%0d]: got %h/%h want 0011/0077", i, a, b); end
            read_en = 1; write_en = 1; a_sel = 3'($urandom_range(1, 7));
            b_sel = 3'($urandom_range(1, 7)); write_sel = 3'($urandom_range(1, 7));
            d_in = 16'($urandom); clear_req = 1'($urandom);
         end else quiet();
         tick();
      end
      quiet();
      n_vec++; if (cnt !== NR - 1) begin n_err++; $display("FAIL clr_busy_len: got %0d want %0d", cnt, NR - 1); end
      for (int r = 0; r < NR; r++) begin
         read_en = 1; a_sel = 3'(r); b_sel = 3'(NR - 1 - r); tick();
         n_vec++; if (a !== 16'h0 || b !== 16'h0) begin
            n_err++; $display("FAIL clr_zero[%0d]: got %h/%h want 0000/0000", r, a, b); end
      end
      quiet();
   endtask

   task automatic test_reset_mid_clear();
      write_en = 1; write_sel = 6; d_in = 16'h0F0F; tick(); quiet();
      read_en = 1; a_sel = 6; b_sel = 6; tick(); quiet();
      clear_req = 1; tick(); quiet();
      tick(); tick();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmc_busy3: got %b want 1", busy); end
      reset = 1; tick(); quiet();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmc_busy: got %b want 0", busy); end
      n_vec++; if (a !== 16'h0 || b !== 16'h0) begin
         n_err++; $display("FAIL rmc_ab: got %h/%h want 0000/0000", a, b); end
      for (int r = 1; r < NR; r++) begin
         read_en = 1; a_sel = 3'(r); b_sel = 3'(r); tick();
         n_vec++; if (a !== 16'h0) begin n_err++; $display("FAIL rmc_zero[%0d]: got %h want 0000", r, a); end
      end
      quiet();
      write_en = 1; write_sel = 6; d_in = 16'h5555; tick(); quiet();
      read_en = 1; a_sel = 6; b_sel = 0; tick(); quiet();
      n_vec++; if (a !== 16'h5555 || b !== 16'h0) begin
         n_err++; $display("FAIL rmc_after: got %h/%h want 5555/0000", a, b); end
   endtask

`ifdef REGFILE_BANKS_EN
   task automatic test_banks();
      int guard;
      bank_sel = 0; write_en = 1; write_sel = 3; d_in = 16'h1111; tick();
      bank_sel = 1; write_en = 1; write_sel = 3; d_in = 16'h2222; tick(); quiet();
      bank_sel = 1; clear_req = 1; tick(); quiet();
      bank_sel = 0;
      guard = 0;
      while (busy === 1'b1 && guard < 20) begin tick(); guard++; end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bank_clr_timeout: busy %b want 0", busy); end
      bank_sel = 0; read_en = 1; a_sel = 3; b_sel = 0; tick(); quiet();
      n_vec++; if (a !== 16'h1111) begin n_err++; $display("FAIL bank0_r3: got %h want 1111", a); end
      bank_sel = 1; read_en = 1; a_sel = 3; b_sel = 3; tick(); quiet();
      n_vec++; if (a !== 16'h0) begin n_err++; $display("FAIL bank1_r3: got %h want 0000", a); end
      bank_sel = 0;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         clear_req = ($urandom_range(0, 29) == 0);
         read_en   = 1'($urandom);
         write_en  = 1'($urandom);
         a_sel     = 3'($urandom);
         b_sel     = ($urandom_range(0, 3) == 0) ? a_sel : 3'($urandom);
         write_sel = ($urandom_range(0, 2) == 0) ? a_sel : 3'($urandom);
         d_in      = 16'($urandom);
         bank_sel  = 1'($urandom);
         tick();
         n_vec++; if (a !== m_a || b !== m_b || busy !== (m_busy_left > 0)) begin
            n_err++;
            $display("FAIL rand[%0d]: got a=%h b=%h busy=%b want a=%h b=%h busy=%b",
                     i, a, b, busy, m_a, m_b, (m_busy_left > 0));
         end
      end
      quiet();
      bank_sel = 0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NR; r++) m_regs[k][r] = 16'h0;
      m_a = 16'h0; m_b = 16'h0; m_busy_left = 0; m_clr_bank = 0;
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_forward();
      test_clear();
      test_reset_mid_clear();
`ifdef REGFILE_BANKS_EN
      test_banks();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
